// File: rtl/dac_write_scheduler.sv
// Shares one 24-bit SPI DAC transmitter between NUM_CH sample channels:
// sends the two configuration words, then round-robin sample writes.
module dac_write_scheduler #(
    parameter int unsigned NUM_CH     = 2,
    parameter logic [23:0] INIT_WORD0 = 24'h380001,
    parameter logic [23:0] INIT_WORD1 = 24'h300003,
    parameter logic [2:0]  WRITE_CMD  = 3'b011
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic [16*NUM_CH-1:0]   i_sample,
    input  logic [NUM_CH-1:0]      i_sample_valid,
    input  logic                   i_dac_ready,
    output logic [23:0]            o_dac_data,
    output logic                   o_dac_send,
    output logic                   o_init_done,
    output logic                   o_busy,
    output logic [NUM_CH-1:0]      o_overrun
);

    localparam int unsigned GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {CFG0, CFG1, IDLE, SEND, WAIT} state_t;

    state_t            state, state_next, ret, ret_next;
    logic [15:0]       hold [NUM_CH];
    logic [15:0]       hold_next [NUM_CH];
    logic [NUM_CH-1:0] pending, pending_next, overrun, overrun_next, grant_vec;
    logic [GW-1:0]     last_grant, last_next, grant_idx;
    logic              grant_found;
    logic [23:0]       data, data_next;
    logic              send, send_next, init_done, init_next, busy, busy_next;

    // Round-robin search starting just above the last granted channel.
    always_comb begin
        int unsigned idx;
        grant_found = 1'b0;
        grant_idx   = last_grant;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            idx = (32'(last_grant) + i) % NUM_CH;
            if (!grant_found && pending[GW'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = GW'(idx);
            end
        end
    end

    always_comb begin
        state_next   = state;
        ret_next     = ret;
        data_next    = data;
        send_next    = send;
        init_next    = init_done;
        pending_next = pending;
        overrun_next = overrun;
        last_next    = last_grant;
        hold_next    = hold;
        grant_vec    = '0;

        case (state)
            CFG0: if (i_dac_ready) begin
                data_next  = INIT_WORD0;
                send_next  = 1'b1;
                ret_next   = CFG1;
                state_next = SEND;
            end
            CFG1: if (i_dac_ready) begin
                data_next  = INIT_WORD1;
                send_next  = 1'b1;
                ret_next   = IDLE;
                state_next = SEND;
            end
            IDLE: if (grant_found && i_dac_ready) begin
                data_next               = {2'b00, WRITE_CMD, 3'(grant_idx), hold[grant_idx]};
                pending_next[grant_idx] = 1'b0;
                grant_vec[grant_idx]    = 1'b1;
                last_next               = grant_idx;
                send_next               = 1'b1;
                ret_next                = IDLE;
                state_next              = SEND;
            end
            SEND: if (!i_dac_ready) begin
                send_next  = 1'b0;
                state_next = WAIT;
            end
            WAIT: if (i_dac_ready) begin
                state_next = ret;
                if (ret == IDLE) init_next = 1'b1;
            end
            default: state_next = CFG0;
        endcase

        // A strobe on the channel being granted re-arms it; the old value is already in data_next.
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (i_sample_valid[k]) begin
                hold_next[k] = i_sample[16*k +: 16];
                if (pending[k] && !grant_vec[k]) overrun_next[k] = 1'b1;
                pending_next[k] = 1'b1;
            end
        end

        busy_next = (state_next == SEND) || (state_next == WAIT);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= CFG0;
            ret        <= CFG1;
            data       <= '0;
            send       <= 1'b0;
            init_done  <= 1'b0;
            busy       <= 1'b0;
            pending    <= '0;
            overrun    <= '0;
            last_grant <= GW'(NUM_CH - 1);
            for (int unsigned k = 0; k < NUM_CH; k++) hold[k] <= '0;
        end else begin
            state      <= state_next;
            ret        <= ret_next;
            data       <= data_next;
            send       <= send_next;
            init_done  <= init_next;
            busy       <= busy_next;
            pending    <= pending_next;
            overrun    <= overrun_next;
            last_grant <= last_next;
            hold       <= hold_next;
        end
    end

    assign o_dac_data  = data;
    assign o_dac_send  = send;
    assign o_init_done = init_done;
    assign o_busy      = busy;
    assign o_overrun   = overrun;

endmodule

// File: tb/tb_dac_write_scheduler.sv
// Randomized bench for dac_write_scheduler with a transaction-level channel
// model and a transmitter model with random ready timing.
module tb_dac_write_scheduler;

    localparam int NCH = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [16*NCH-1:0]    sample;
    logic [NCH-1:0]       valid;
    logic                 ready;
    logic [23:0]          dac_data;
    logic                 dac_send;
    logic                 init_done;
    logic                 busy;
    logic [NCH-1:0]       overrun;

    always #5 clk = ~clk;

    dac_write_scheduler #(.NUM_CH(NCH)) dut (
        .i_clock        (clk),
        .i_reset_n      (rst_n),
        .i_sample       (sample),
        .i_sample_valid (valid),
        .i_dac_ready    (ready),
        .o_dac_data     (dac_data),
        .o_dac_send     (dac_send),
        .o_init_done    (init_done),
        .o_busy         (busy),
        .o_overrun      (overrun)
    );

    int tests = 0;
    int fails = 0;

    // Model: latest value and pending flag per channel, sticky overrun, last grant.
    logic [15:0]    m_val [NCH];
    logic [NCH-1:0] m_pend, m_ovr;
    int             m_last, nsends;
    logic           prev_send, prev_init;
    logic [23:0]    cur_word;
    logic [23:0]    log_w [$];
    int             x_state, x_cnt;
    bit             x_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        nsends    = 0;
        m_pend    = '0;
        m_ovr     = '0;
        m_last    = NCH - 1;
        prev_send = 1'b0;
        prev_init = 1'b0;
        for (int k = 0; k < NCH; k++) m_val[k] = '0;
    endtask

    task automatic step();
        int ch;
        @(posedge clk);
        #1;
        if (dac_send && !prev_send) begin
            nsends++;
            if (nsends == 1) check("cfg_word0", dac_data, 24'h380001);
            else if (nsends == 2) check("cfg_word1", dac_data, 24'h300003);
            else begin
                check("init_before_sample", init_done, 1);
                ch = -1;
                for (int i = 1; i <= NCH; i++) begin
                    int c = (m_last + i) % NCH;
                    if (ch < 0 && m_pend[c]) ch = c;
                end
                if (ch < 0) check("spurious_send", dac_send, 0);
                else begin
                    check("sample_word", dac_data, {2'b00, 3'b011, 3'(ch), m_val[ch]});
                    m_pend[ch] = 1'b0;
                    m_last     = ch;
                    log_w.push_back(dac_data);
                end
            end
            cur_word = dac_data;
            if (x_en) begin
                x_state = 1;
                x_cnt   = $urandom_range(0, 2);
            end
        end else if (busy) check("data_stable", dac_data, cur_word);
        if (dac_send) check("busy_with_send", busy, 1);
        if (init_done && !prev_init) begin
            check("init_after_cfg", nsends, 2);
            check("init_idle", busy, 0);
        end
        for (int k = 0; k < NCH; k++) begin
            if (valid[k]) begin
                if (m_pend[k]) m_ovr[k] = 1'b1;
                m_val[k]  = sample[16*k +: 16];
                m_pend[k] = 1'b1;
            end
        end
        check("overrun", overrun, m_ovr);
        prev_send = dac_send;
        prev_init = init_done;
        valid     = '0;
        if (x_en) begin
            case (x_state)
                1: if (x_cnt == 0) begin
                    ready   = 1'b0;
                    x_state = 2;
                    x_cnt   = $urandom_range(2, 6);
                end else x_cnt--;
                2: if (x_cnt == 0) begin
                    ready   = 1'b1;
                    x_state = 0;
                end else x_cnt--;
                default: ;
            endcase
        end
    endtask

    task automatic wait_quiet(input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            if (!busy && !dac_send && m_pend == '0 && x_state == 0) done = 1;
        end
        check("quiet_timeout", done, 1);
        step();
    endtask

    task automatic wait_sends(input int target, input int budget);
        for (int i = 0; i < budget && nsends < target; i++) step();
        check("send_timeout", nsends >= target, 1);
    endtask

    task automatic wait_not_busy(input int budget);
        for (int i = 0; i < budget && busy; i++) step();
        check("busy_timeout", busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, dac_data, 0);
        check({tag, "_send"}, dac_send, 0);
        check({tag, "_init"}, init_done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ovr"}, overrun, 0);
    endtask

    initial begin
        int start, n;
        rst_n   = 1'b0;
        ready   = 1'b1;
        valid   = '0;
        sample  = '0;
        x_en    = 1;
        x_state = 0;
        x_cnt   = 0;
        model_reset();

        repeat (3) step();
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Configuration sequence
        for (int i = 0; i < 100 && !init_done; i++) step();
        check("init_done", init_done, 1);
        check("init_words", nsends, 2);

        // Two channels strobed together
        wait_quiet(50);
        sample = {16'hABCD, 16'h1234};
        valid  = 2'b11;
        wait_quiet(200);
        check("pair_first", log_w[log_w.size()-2], 24'h181234);
        check("pair_second", log_w[log_w.size()-1], 24'h19ABCD);

        // Fairness: re-strobe the channel just served after each word
        start  = log_w.size();
        sample = {16'h1111, 16'h0000};
        valid  = 2'b11;
        for (int r = 0; r < 5; r++) begin
            wait_sends(nsends + 1, 100);
            wait_not_busy(100);
            n = int'(log_w[log_w.size()-1][18:16]);
            sample[16*n +: 16] = 16'(r * 16'h0101 + 16'h0202);
            valid[n] = 1'b1;
        end
        wait_quiet(200);
        for (int i = start; i < log_w.size(); i++)
            check("fair_alt", log_w[i][18:16], (i - start) % 2);
        check("fair_no_ovr", overrun, 0);

        // Latency from strobe to send
        wait_quiet(50);
        sample[15:0] = 16'h0777;
        valid        = 2'b01;
        step();
        check("lat_n1", dac_send, 0);
        step();
        check("lat_n2", dac_send, 1);
        check("lat_word", dac_data, 24'h180777);

        // Re-strobe on the grant cycle
        wait_quiet(50);
        sample[15:0] = 16'h4444;
        valid        = 2'b01;
        step();
        sample[15:0] = 16'h5555;
        valid        = 2'b01;
        step();
        wait_quiet(200);
        check("same_first", log_w[log_w.size()-2], 24'h184444);
        check("same_second", log_w[log_w.size()-1], 24'h185555);
        check("same_no_ovr", overrun[0], 0);

        // Overrun while a word is in flight
        wait_quiet(50);
        sample[15:0] = 16'h2222;
        valid        = 2'b01;
        step();
        step();
        sample[31:16] = 16'h0001;
        valid         = 2'b10;
        step();
        sample[31:16] = 16'h0002;
        valid         = 2'b10;
        step();
        wait_quiet(200);
        check("ovr_word", log_w[log_w.size()-1], 24'h190002);
        n = 0;
        foreach (log_w[i]) if (log_w[i] == 24'h190001) n++;
        check("ovr_dropped", n, 0);
        check("ovr_flag", overrun, 2'b10);
        repeat (10) step();
        check("ovr_sticky", overrun, 2'b10);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NCH; k++) begin
                if ($urandom_range(0, 15) == 0) begin
                    valid[k] = 1'b1;
                    sample[16*k +: 16] = 16'($urandom);
                end
            end
            step();
        end
        wait_quiet(500);

        // Reset while in SEND with the transmitter busy
        sample[15:0] = 16'h6789;
        valid        = 2'b01;
        step();
        step();
        check("pre_rst_send", dac_send, 1);
        x_en    = 0;
        x_state = 0;
        ready   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst_wait_ready", dac_send, 0);
        end
        x_en  = 1;
        ready = 1'b1;
        wait_sends(1, 20);
        for (int i = 0; i < 100 && !init_done; i++) step();
        check("reinit_done", init_done, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
